// File: rtl/rx_fifo.sv
// rx_fifo: receive-side flit buffer, first-word-fall-through.
// Status flags decode from the registered occupancy only.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module rx_fifo #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write,
  input  logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] item_in,
  output logic                       full,
  output logic                       afull,
  output logic                       valid,
  output logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] item_out,
  input  logic                       read,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int W  = `PAYLOAD_SIZE + `ADDR_SZ;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Push never looks at read, so a full FIFO drops writes even
  // when a pop happens in the same cycle.
  assign push = write & ~full;
  assign pop  = read & valid;

  assign full     = (count == CW'(DEPTH));
  assign afull    = (count >= CW'(AFULL_LVL));
  assign valid    = (count != '0);
  assign item_out = mem[rd_ptr];

  // Storage is left unreset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= item_in;
  end

  // Pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (write && full)  ovf <= 1'b1;
      if (read  && !valid) udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed checks of rx_fifo at DEPTH=4, AFULL_LVL=3.
// Expected values are hand-derived; a small queue tracks streaming order.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_rx_fifo;

  localparam int W = `PAYLOAD_SIZE + `ADDR_SZ;

  logic         clk;
  logic         rst_n;
  logic         write;
  logic [W-1:0] item_in;
  logic         full;
  logic         afull;
  logic         valid;
  logic [W-1:0] item_out;
  logic         read;
  logic [2:0]   count;
  logic         ovf;
  logic         udf;

  int nchk = 0;
  int nerr = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_item;

  rx_fifo #(.DEPTH(4), .AFULL_LVL(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write(write),
    .item_in(item_in),
    .full(full),
    .afull(afull),
    .valid(valid),
    .item_out(item_out),
    .read(read),
    .count(count),
    .ovf(ovf),
    .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    write   = 1'b1;
    item_in = d;
    tick();
    write   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    item_in = '0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full",  32'(full),  0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_udf",   32'(udf),   0);
    rst_n = 1'b1;
    tick();

    // single push falls through immediately
    push(12'h0A1);
    chk("p1_valid", 32'(valid), 1);
    chk("p1_item",  32'(item_out), 32'h0A1);
    chk("p1_count", 32'(count), 1);
    chk("p1_full",  32'(full), 0);

    // fill to full
    push(12'h0B2);
    chk("p2_afull", 32'(afull), 0);
    push(12'h0C3);
    chk("p3_afull", 32'(afull), 1);
    chk("p3_full",  32'(full), 0);
    push(12'h0D4);
    chk("p4_full",  32'(full), 1);
    chk("p4_count", 32'(count), 4);

    // write while full is dropped
    push(12'h0E5);
    chk("ovf_set",   32'(ovf), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_head",  32'(item_out), 32'h0A1);

    // write+read while full: pop A, drop new flit
    write   = 1'b1;
    read    = 1'b1;
    item_in = 12'h0E6;
    tick();
    write = 1'b0;
    read  = 1'b0;
    chk("fwr_count", 32'(count), 3);
    chk("fwr_head",  32'(item_out), 32'h0B2);
    chk("fwr_full",  32'(full), 0);

    // pop B to reach count=2
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("pop_count", 32'(count), 2);
    chk("pop_head",  32'(item_out), 32'h0C3);

    // steady stream across wraps
    q.push_back(12'h0C3);
    q.push_back(12'h0D4);
    for (int i = 0; i < 10; i++) begin
      exp_item = q.pop_front();
      chk("strm_head", 32'(item_out), 32'(exp_item));
      q.push_back(12'h100 + 12'(i));
      write   = 1'b1;
      read    = 1'b1;
      item_in = 12'h100 + 12'(i);
      tick();
      chk("strm_count", 32'(count), 2);
    end
    write = 1'b0;
    read  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_item = q.pop_front();
      chk("drain_head", 32'(item_out), 32'(exp_item));
      tick();
    end
    read = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(valid), 0);
    chk("drain_udf",   32'(udf), 0);

    // read while empty
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("udf_set",   32'(udf), 1);
    chk("udf_count", 32'(count), 0);
    chk("udf_valid", 32'(valid), 0);

    // write+read while empty: push wins, pop ignored
    write   = 1'b1;
    read    = 1'b1;
    item_in = 12'h0F7;
    tick();
    write = 1'b0;
    read  = 1'b0;
    chk("wre_count", 32'(count), 1);
    chk("wre_item",  32'(item_out), 32'h0F7);

    // three stored, async reset between edges
    push(12'h018);
    push(12'h029);
    chk("pre_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_ovf",   32'(ovf), 0);
    chk("ar_udf",   32'(udf), 0);
    chk("ar_afull", 32'(afull), 0);
    #1;
    rst_n = 1'b1;
    tick();

    // behaves as empty after reset
    push(12'h03A);
    chk("post_count", 32'(count), 1);
    chk("post_item",  32'(item_out), 32'h03A);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of flit entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AFULL_LVL, default DEPTH-1, occupancy at or above which afull asserts.
REQ-003 Flit width W SHALL equal `PAYLOAD_SIZE+`ADDR_SZ on every flit port.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 write  input  1  upstream arbiter push strobe.
REQ-007 item_in  input  W  flit to push.
REQ-008 full  output  1  occupancy == DEPTH; feeds the arbiter's full input.
REQ-009 afull  output  1  occupancy >= AFULL_LVL.
REQ-010 valid  output  1  occupancy != 0; head flit presented on item_out.
REQ-011 item_out  output  W  head flit, first-word-fall-through.
REQ-012 read  input  1  downstream pop strobe.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 ovf  output  1  sticky: write seen while full.
REQ-015 udf  output  1  sticky: read seen while not valid.

Function
REQ-016 Storage SHALL be DEPTH x W registers with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH with no extra logic.
REQ-017 Push accepted when write=1 and full=0: mem[wr_ptr]<=item_in, wr_ptr increments.
REQ-018 Pop accepted when read=1 and valid=0 is false: rd_ptr increments; popped entry contents are don't-care afterwards.
REQ-019 full, afull, valid SHALL decode from registered count only; no combinational path from write or read to any output.
REQ-020 Acceptance of a push SHALL NOT depend on a same-cycle pop; write while full is dropped even if read=1.
REQ-021 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-022 Write and read while empty: push accepted, pop ignored, count becomes 1, udf sets.
REQ-023 count SHALL be +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-024 Latency: flit pushed at edge k SHALL appear on item_out with valid=1 immediately after edge k when FIFO was empty.
REQ-025 item_out SHALL equal mem[rd_ptr] combinationally; value undefined-but-stable when valid=0.
REQ-026 Order SHALL be strict FIFO across pointer wrap-around.
REQ-027 ovf SHALL set on the edge where write=1 and full=1; udf on the edge where read=1 and valid=0; both hold until reset.
REQ-028 Dropped writes and ignored reads SHALL NOT modify mem, pointers or count.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, count, ovf, udf; outputs full=0, afull=0 (DEPTH>1, AFULL_LVL>0), valid=0, count=0.
REQ-030 mem contents SHALL NOT be reset.
REQ-031 Reset asserted mid-traffic SHALL discard all stored flits; first edge after deassertion behaves as empty FIFO.
REQ-032 Deassertion SHALL be used synchronously; no push/pop on the edge coincident with release is required to be accepted.

Verification (DEPTH=4, AFULL_LVL=3)
REQ-033 Reset, push A -> next cycle valid=1, item_out=A, count=1, full=0.
REQ-034 Push A,B,C,D back-to-back, no reads -> afull=1 after C, full=1 count=4 after D; push E with read=0 -> dropped, ovf=1, count=4.
REQ-035 Full FIFO, write=1 and read=1 same cycle -> A popped, E dropped, count=3, next item_out=B.
REQ-036 Steady push+pop every cycle for 10 flits starting from count=2 -> count stays 2, output order equals input order across two pointer wraps.
REQ-037 Empty FIFO, read=1 alone -> udf=1, count=0, pointers unchanged; then write+read together -> count=1, item_out=new flit.
REQ-038 Three flits stored, rst_n pulsed low between edges -> valid=0, count=0, ovf=udf=0 immediately, without a clock edge.
